dmr_recovery_pc: RTL and testbench



---
 rtl/dmr_recovery_pc.sv | 152 +++++++++++++++
 tb/tb_dmr_recovery_pc.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmr_recovery_pc.sv
// Recovery PC buffer for one DMR group: keeps a short history of retired PCs and,
// on a restore request, reloads the halted core pair with the oldest safe PC.
module dmr_recovery_pc #(
    parameter int unsigned          PCWidth  = 32,
    parameter int unsigned          Depth    = 2,
    parameter logic [PCWidth-1:0]   BootAddr = PCWidth'(32'h1A00_0080),
    localparam int unsigned         CntW     = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                pc_write_enable_i,
    input  logic                pc_read_enable_i,
    input  logic                commit_valid_i,
    input  logic [PCWidth-1:0]  commit_pc_i,
    output logic [PCWidth-1:0]  recovery_pc_o,
    output logic                recovery_pc_we_o,
    output logic [CntW-1:0]     history_count_o,
    output logic                empty_restore_o
);

    typedef enum logic [1:0] {
        ST_TRACK   = 2'd0,
        ST_FROZEN  = 2'd1,
        ST_RESTORE = 2'd2,
        ST_RESYNC  = 2'd3
    } state_e;

    state_e               r_state;
    logic [PCWidth-1:0]   r_hist [Depth];
    logic [CntW-1:0]      r_count;
    logic [PCWidth-1:0]   r_pc;
    logic                 r_we;
    logic                 r_empty;

    state_e               w_state_nxt;
    logic [PCWidth-1:0]   w_hist_nxt [Depth];
    logic [CntW-1:0]      w_count_nxt;
    logic [PCWidth-1:0]   w_pc_nxt;
    logic                 w_we_nxt;
    logic                 w_empty_nxt;
    logic [PCWidth-1:0]   w_oldest;

    // Oldest valid entry, or the boot address when the history is empty
    always_comb begin
        w_oldest = BootAddr;
        for (int k = 0; k < int'(Depth); k++) begin
            if (r_count == CntW'(k + 1)) begin
                w_oldest = r_hist[k];
            end
        end
    end

    // Next-state and next-value logic; clear_i overrides every state transition
    always_comb begin
        w_state_nxt = r_state;
        w_hist_nxt  = r_hist;
        w_count_nxt = r_count;
        w_pc_nxt    = r_pc;
        w_we_nxt    = 1'b0;
        w_empty_nxt = r_empty;

        if (clear_i) begin
            for (int k = 0; k < int'(Depth); k++) begin
                w_hist_nxt[k] = BootAddr;
            end
            if (r_state == ST_RESYNC) begin
                w_hist_nxt[0] = r_pc;
                w_count_nxt   = CntW'(1);
            end else begin
                w_count_nxt = '0;
                if (r_state != ST_RESTORE) begin
                    w_empty_nxt = 1'b0;
                end
            end
            w_state_nxt = ST_TRACK;
        end else if (pc_read_enable_i && (r_state != ST_RESYNC)) begin
            w_we_nxt    = 1'b1;
            w_pc_nxt    = w_oldest;
            w_state_nxt = ST_RESTORE;
            if (r_count == '0) begin
                w_empty_nxt = 1'b1;
            end
        end else begin
            unique case (r_state)
                ST_TRACK: begin
                    if (!pc_write_enable_i) begin
                        w_state_nxt = ST_FROZEN;
                    end else if (commit_valid_i) begin
                        for (int k = int'(Depth) - 1; k > 0; k--) begin
                            w_hist_nxt[k] = r_hist[k-1];
                        end
                        w_hist_nxt[0] = commit_pc_i;
                        if (r_count != CntW'(Depth)) begin
                            w_count_nxt = r_count + CntW'(1);
                        end
                    end
                end
                ST_FROZEN: begin
                    if (pc_write_enable_i) begin
                        w_state_nxt = ST_TRACK;
                    end
                end
                ST_RESTORE: begin
                    w_state_nxt = ST_RESYNC;
                end
                ST_RESYNC: begin
                    // Restart tracking from the PC the cores were reloaded with
                    if (pc_write_enable_i) begin
                        for (int k = 0; k < int'(Depth); k++) begin
                            w_hist_nxt[k] = BootAddr;
                        end
                        w_hist_nxt[0] = r_pc;
                        w_count_nxt   = CntW'(1);
                        w_state_nxt   = ST_TRACK;
                    end
                end
                default: begin
                    w_state_nxt = ST_TRACK;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_TRACK;
            for (int k = 0; k < int'(Depth); k++) begin
                r_hist[k] <= BootAddr;
            end
            r_count <= '0;
            r_pc    <= BootAddr;
            r_we    <= 1'b0;
            r_empty <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            for (int k = 0; k < int'(Depth); k++) begin
                r_hist[k] <= w_hist_nxt[k];
            end
            r_count <= w_count_nxt;
            r_pc    <= w_pc_nxt;
            r_we    <= w_we_nxt;
            r_empty <= w_empty_nxt;
        end
    end

    assign recovery_pc_o    = r_pc;
    assign recovery_pc_we_o = r_we;
    assign history_count_o  = r_count;
    assign empty_restore_o  = r_empty;

endmodule

// File: tb/tb_dmr_recovery_pc.sv
// Bench for dmr_recovery_pc: Depth=2 and Depth=4 instances share stimulus and are
// compared each cycle against a queue-style reference model plus directed constants.
module tb_dmr_recovery_pc;

    localparam logic [31:0] BOOT = 32'h1A00_0080;
    localparam int M_TRACK   = 0;
    localparam int M_FROZEN  = 1;
    localparam int M_RESTORE = 2;
    localparam int M_RESYNC  = 3;

    logic        clk = 1'b0;
    logic        rst, clr, wen, rd, cv;
    logic [31:0] cpc;
    logic [31:0] pc2, pc4;
    logic        we2, we4, emp2, emp4;
    logic [1:0]  cnt2;
    logic [2:0]  cnt4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmr_recovery_pc #(.PCWidth(32), .Depth(2), .BootAddr(BOOT)) dut2 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .pc_write_enable_i(wen),
        .pc_read_enable_i(rd), .commit_valid_i(cv), .commit_pc_i(cpc),
        .recovery_pc_o(pc2), .recovery_pc_we_o(we2), .history_count_o(cnt2),
        .empty_restore_o(emp2)
    );

    dmr_recovery_pc #(.PCWidth(32), .Depth(4), .BootAddr(BOOT)) dut4 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .pc_write_enable_i(wen),
        .pc_read_enable_i(rd), .commit_valid_i(cv), .commit_pc_i(cpc),
        .recovery_pc_o(pc4), .recovery_pc_we_o(we4), .history_count_o(cnt4),
        .empty_restore_o(emp4)
    );

    // Reference model: index 0 -> Depth 2, index 1 -> Depth 4; m_q[i][0] is newest
    int          m_depth [2] = '{2, 4};
    logic [31:0] m_q     [2][4];
    int          m_n     [2];
    int          m_mode  [2];
    logic [31:0] m_pc    [2];
    logic        m_we    [2];
    logic        m_emp   [2];

    function automatic void model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_n[i] = 0; m_mode[i] = M_TRACK; m_pc[i] = BOOT;
                m_we[i] = 1'b0; m_emp[i] = 1'b0;
            end else if (clr) begin
                if (m_mode[i] == M_RESYNC) begin
                    m_q[i][0] = m_pc[i];
                    m_n[i] = 1;
                end else begin
                    m_n[i] = 0;
                    if (m_mode[i] != M_RESTORE) m_emp[i] = 1'b0;
                end
                m_we[i] = 1'b0;
                m_mode[i] = M_TRACK;
            end else begin
                m_we[i] = 1'b0;
                if (rd && m_mode[i] != M_RESYNC) begin
                    m_we[i] = 1'b1;
                    m_pc[i] = (m_n[i] > 0) ? m_q[i][m_n[i]-1] : BOOT;
                    if (m_n[i] == 0) m_emp[i] = 1'b1;
                    m_mode[i] = M_RESTORE;
                end else begin
                    case (m_mode[i])
                        M_TRACK: begin
                            if (!wen) m_mode[i] = M_FROZEN;
                            else if (cv) begin
                                for (int j = m_depth[i] - 1; j > 0; j--) m_q[i][j] = m_q[i][j-1];
                                m_q[i][0] = cpc;
                                if (m_n[i] < m_depth[i]) m_n[i]++;
                            end
                        end
                        M_FROZEN:  if (wen) m_mode[i] = M_TRACK;
                        M_RESTORE: m_mode[i] = M_RESYNC;
                        default: begin
                            if (wen) begin
                                m_q[i][0] = m_pc[i];
                                m_n[i] = 1;
                                m_mode[i] = M_TRACK;
                            end
                        end
                    endcase
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc_d2",  pc2, m_pc[0]);
        chk("we_d2",  32'(we2), 32'(m_we[0]));
        chk("cnt_d2", 32'(cnt2), 32'(m_n[0]));
        chk("emp_d2", 32'(emp2), 32'(m_emp[0]));
        chk("pc_d4",  pc4, m_pc[1]);
        chk("we_d4",  32'(we4), 32'(m_we[1]));
        chk("cnt_d4", 32'(cnt4), 32'(m_n[1]));
        chk("emp_d4", 32'(emp4), 32'(m_emp[1]));
    endtask

    task automatic step(input logic r, input logic c, input logic w, input logic d,
                        input logic v, input logic [31:0] p);
        rst = r; clr = c; wen = w; rd = d; cv = v; cpc = p;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wen = 1'b1; rd = 1'b0; cv = 1'b0; cpc = '0;

        // 1: fill the Depth-2 history past saturation
        step(1, 0, 1, 0, 0, 0);
        chk("reset_pc", pc2, BOOT);
        step(0, 0, 1, 0, 1, 32'h100);
        step(0, 0, 1, 0, 1, 32'h104);
        step(0, 0, 1, 0, 1, 32'h108);
        chk("t1_cnt", 32'(cnt2), 32'd2);
        chk("t1_we", 32'(we2), 32'd0);

        // 2: freeze with a same-cycle commit, then two-cycle restore
        step(0, 0, 0, 0, 1, 32'h10C);
        step(0, 0, 0, 1, 0, 0);
        chk("t2_pc_a", pc2, 32'h104);
        chk("t2_we_a", 32'(we2), 32'd1);
        step(0, 0, 0, 1, 0, 0);
        chk("t2_pc_b", pc2, 32'h104);
        step(0, 0, 0, 0, 0, 0);
        chk("t2_we_off", 32'(we2), 32'd0);

        // 3: resync from the restored PC, then capture again
        step(0, 0, 1, 0, 0, 0);
        chk("t3_cnt1", 32'(cnt2), 32'd1);
        step(0, 0, 1, 0, 1, 32'h200);
        chk("t3_cnt2", 32'(cnt2), 32'd2);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("t3_oldest", pc2, 32'h104);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);

        // 4: restore from an empty history, then clear in TRACK
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("t4_pc", pc2, BOOT);
        chk("t4_emp", 32'(emp2), 32'd1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("t4_emp_hold", 32'(emp2), 32'd1);
        step(0, 1, 1, 0, 0, 0);
        chk("t4_emp_clr", 32'(emp2), 32'd0);
        chk("t4_cnt", 32'(cnt2), 32'd0);

        // 5: reset in the second restore cycle
        step(0, 0, 1, 0, 1, 32'h300);
        step(0, 0, 0, 1, 0, 0);
        chk("t5_pc_pre", pc2, 32'h300);
        step(1, 0, 0, 1, 0, 0);
        chk("t5_we", 32'(we2), 32'd0);
        chk("t5_cnt", 32'(cnt2), 32'd0);
        chk("t5_pc", pc2, BOOT);

        // 6: continuous commits saturate both histories
        step(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 16; k++) step(0, 0, 1, 0, 1, 32'(k * 4));
        chk("t6_cnt4", 32'(cnt4), 32'd4);
        step(0, 0, 0, 1, 0, 0);
        chk("t6_pc4", pc4, 32'h30);
        chk("t6_pc2", pc2, 32'h38);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            step(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                 ($urandom_range(3) != 0), ($urandom_range(5) == 0),
                 ($urandom_range(1) == 1), {$urandom_range(32'h3FFF_FFFF), 2'b00});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
